// File: rtl/nor_cmd_pkg.sv
// Shared constants for the NOR command sequencer: op codes, FSM states,
// unlock-cycle addresses/data and per-op sequence lengths.
package nor_cmd_pkg;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_PROGRAM = 2'b01,
      OP_ERASE   = 2'b10,
      OP_RSVD    = 2'b11
   } op_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ISSUE    = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK = 3'd2;
   localparam logic [2:0] ST_SETTLE   = 3'd3;
   localparam logic [2:0] ST_POLL     = 3'd4;
   localparam logic [2:0] ST_RESP     = 3'd5;

   localparam logic [11:0] UNLOCK_ADDR1     = 12'h555;
   localparam logic [11:0] UNLOCK_ADDR2     = 12'h2AA;
   localparam logic [7:0]  UNLOCK_DATA1     = 8'hAA;
   localparam logic [7:0]  UNLOCK_DATA2     = 8'h55;
   localparam logic [7:0]  CMD_PROGRAM      = 8'hA0;
   localparam logic [7:0]  CMD_ERASE_SETUP  = 8'h80;
   localparam logic [7:0]  CMD_SECTOR_ERASE = 8'h30;

   localparam int SEQ_LEN_READ    = 1;
   localparam int SEQ_LEN_PROGRAM = 4;
   localparam int SEQ_LEN_ERASE   = 6;

   typedef enum logic [1:0] {ASEL_555, ASEL_2AA, ASEL_CMD} asel_t;
   typedef enum logic [2:0] {DSEL_AA, DSEL_55, DSEL_A0, DSEL_80, DSEL_30, DSEL_CMD, DSEL_ZERO} dsel_t;

endpackage

// File: rtl/nor_cmd_seq_if.sv
// Wishbone pipelined bus bundle between the sequencer and the NOR slave.
interface nor_cmd_seq_if #(
   parameter int ADDRBITS = 26,
   parameter int DATABITS = 16
);
   logic                cyc;
   logic                stb;
   logic                we;
   logic [ADDRBITS-1:0] adr;
   logic [DATABITS-1:0] dat_w;
   logic [DATABITS-1:0] dat_r;
   logic                ack;
   logic                stall;

   modport master (output cyc, stb, we, adr, dat_w, input  ack, stall, dat_r);
   modport slave  (input  cyc, stb, we, adr, dat_w, output ack, stall, dat_r);
endinterface

// File: rtl/nor_cmd_rom.sv
// Combinational step table: per op and step index, which address/data to
// drive, write enable, and whether this is the final bus step.
module nor_cmd_rom
   import nor_cmd_pkg::*;
(
   input  logic [1:0] i_op,
   input  logic [2:0] i_step,
   output asel_t      o_addr_sel,
   output dsel_t      o_data_sel,
   output logic       o_we,
   output logic       o_last
);

   always_comb begin
      o_addr_sel = ASEL_CMD;
      o_data_sel = DSEL_ZERO;
      o_we       = 1'b0;
      o_last     = 1'b1;
      case (i_op)
         OP_READ: begin
            o_last = (i_step == 3'(SEQ_LEN_READ - 1));
         end
         OP_PROGRAM: begin
            o_we   = 1'b1;
            o_last = (i_step == 3'(SEQ_LEN_PROGRAM - 1));
            case (i_step)
               3'd0:    begin o_addr_sel = ASEL_555; o_data_sel = DSEL_AA; end
               3'd1:    begin o_addr_sel = ASEL_2AA; o_data_sel = DSEL_55; end
               3'd2:    begin o_addr_sel = ASEL_555; o_data_sel = DSEL_A0; end
               default: begin o_addr_sel = ASEL_CMD; o_data_sel = DSEL_CMD; end
            endcase
         end
         OP_ERASE: begin
            o_we   = 1'b1;
            o_last = (i_step == 3'(SEQ_LEN_ERASE - 1));
            case (i_step)
               3'd0:    begin o_addr_sel = ASEL_555; o_data_sel = DSEL_AA; end
               3'd1:    begin o_addr_sel = ASEL_2AA; o_data_sel = DSEL_55; end
               3'd2:    begin o_addr_sel = ASEL_555; o_data_sel = DSEL_80; end
               3'd3:    begin o_addr_sel = ASEL_555; o_data_sel = DSEL_AA; end
               3'd4:    begin o_addr_sel = ASEL_2AA; o_data_sel = DSEL_55; end
               default: begin o_addr_sel = ASEL_CMD; o_data_sel = DSEL_30; end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/nor_cmd_seq.sv
// NOR flash command sequencer: issues READ / PROGRAM / SECTOR_ERASE bus
// sequences and polls RY. Define NOR_CMD_VERIFY_EN to add a readback check.
module nor_cmd_seq
   import nor_cmd_pkg::*;
#(
   parameter int          ADDRBITS       = 26,
   parameter int          DATABITS       = 16,
   parameter int          SETTLE_CYCLES  = 4,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [ADDRBITS-1:0] cmd_addr_i,
   input  logic [DATABITS-1:0] cmd_data_i,
   output logic                rsp_valid_o,
   output logic [DATABITS-1:0] rsp_data_o,
   output logic                rsp_err_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [ADDRBITS-1:0] wbm_adr_o,
   output logic [DATABITS-1:0] wbm_dat_o,
   input  logic                wbm_ack_i,
   input  logic                wbm_stall_i,
   input  logic [DATABITS-1:0] wbm_dat_i,
   input  logic                nor_ry_i
);

   logic [2:0]          r_state;
   logic [1:0]          r_op;
   logic [ADDRBITS-1:0] r_addr;
   logic [DATABITS-1:0] r_data;
   logic [2:0]          r_step;
   logic                r_last;
   logic                r_verify;
   logic [23:0]         r_cnt;
   logic                r_cyc, r_stb, r_we;
   logic [ADDRBITS-1:0] r_adr;
   logic [DATABITS-1:0] r_dat;
   logic                r_rsp_valid, r_rsp_err;
   logic [DATABITS-1:0] r_rsp_data;

   logic                w_idle;
   logic [1:0]          w_rom_op;
   logic [2:0]          w_rom_step;
   asel_t               w_asel;
   dsel_t               w_dsel;
   logic                w_we, w_last;
   logic [ADDRBITS-1:0] w_cmd_adr, w_adr;
   logic [DATABITS-1:0] w_cmd_dat, w_dat, w_verify_exp;

   // The ROM always looks up the step about to be issued, so the bus
   // registers can be loaded on the same edge that advances the step.
   assign w_idle       = (r_state == ST_IDLE);
   assign w_rom_op     = w_idle ? cmd_op_i   : r_op;
   assign w_rom_step   = w_idle ? 3'd0       : r_step + 3'd1;
   assign w_cmd_adr    = w_idle ? cmd_addr_i : r_addr;
   assign w_cmd_dat    = w_idle ? cmd_data_i : r_data;
   assign w_verify_exp = (r_op == OP_PROGRAM) ? r_data : '1;

   nor_cmd_rom u_rom (
      .i_op       (w_rom_op),
      .i_step     (w_rom_step),
      .o_addr_sel (w_asel),
      .o_data_sel (w_dsel),
      .o_we       (w_we),
      .o_last     (w_last)
   );

   always_comb begin
      case (w_asel)
         ASEL_555: w_adr = ADDRBITS'(UNLOCK_ADDR1);
         ASEL_2AA: w_adr = ADDRBITS'(UNLOCK_ADDR2);
         default:  w_adr = w_cmd_adr;
      endcase
      case (w_dsel)
         DSEL_AA:  w_dat = DATABITS'(UNLOCK_DATA1);
         DSEL_55:  w_dat = DATABITS'(UNLOCK_DATA2);
         DSEL_A0:  w_dat = DATABITS'(CMD_PROGRAM);
         DSEL_80:  w_dat = DATABITS'(CMD_ERASE_SETUP);
         DSEL_30:  w_dat = DATABITS'(CMD_SECTOR_ERASE);
         DSEL_CMD: w_dat = w_cmd_dat;
         default:  w_dat = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= ST_IDLE;
         r_op        <= 2'b00;
         r_addr      <= '0;
         r_data      <= '0;
         r_step      <= 3'd0;
         r_last      <= 1'b0;
         r_verify    <= 1'b0;
         r_cnt       <= 24'd0;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  r_op     <= cmd_op_i;
                  r_addr   <= cmd_addr_i;
                  r_data   <= cmd_data_i;
                  r_step   <= 3'd0;
                  r_verify <= 1'b0;
                  if (cmd_op_i == OP_RSVD) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_cyc   <= 1'b1;
                     r_stb   <= 1'b1;
                     r_we    <= w_we;
                     r_adr   <= w_adr;
                     r_dat   <= w_dat;
                     r_last  <= w_last;
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (!wbm_stall_i) begin
                  r_stb   <= 1'b0;
                  r_state <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (wbm_ack_i) begin
                  if (r_verify) begin
                     r_cyc       <= 1'b0;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= wbm_dat_i;
                     r_rsp_err   <= (wbm_dat_i != w_verify_exp);
                     r_state     <= ST_RESP;
                  end else if (!r_last) begin
                     r_step  <= r_step + 3'd1;
                     r_stb   <= 1'b1;
                     r_we    <= w_we;
                     r_adr   <= w_adr;
                     r_dat   <= w_dat;
                     r_last  <= w_last;
                     r_state <= ST_ISSUE;
                  end else if (r_op == OP_READ) begin
                     r_cyc       <= 1'b0;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= wbm_dat_i;
                     r_rsp_err   <= 1'b0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_cyc   <= 1'b0;
                     r_we    <= 1'b0;
                     r_cnt   <= 24'd0;
                     r_state <= ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_cnt + 24'd1 >= 24'(SETTLE_CYCLES)) begin
                  r_cnt   <= 24'd0;
                  r_state <= ST_POLL;
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end
            ST_POLL: begin
               // RY is checked before the timeout so a coincident RY wins
               if (nor_ry_i) begin
`ifdef NOR_CMD_VERIFY_EN
                  r_verify <= 1'b1;
                  r_cyc    <= 1'b1;
                  r_stb    <= 1'b1;
                  r_we     <= 1'b0;
                  r_adr    <= r_addr;
                  r_dat    <= '0;
                  r_last   <= 1'b1;
                  r_state  <= ST_ISSUE;
`else
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
`endif
               end else if (r_cnt + 24'd1 >= TIMEOUT_CYCLES) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = w_idle;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;
   assign wbm_cyc_o   = r_cyc;
   assign wbm_stb_o   = r_stb;
   assign wbm_we_o    = r_we;
   assign wbm_adr_o   = r_adr;
   assign wbm_dat_o   = r_dat;

endmodule

// File: tb/tb_nor_cmd_seq.sv
// Scoreboard bench for nor_cmd_seq: expected bus ops and responses are queued
// by the stimulus and popped by independent bus/response monitors.
module tb_nor_cmd_seq;

   localparam int          TB_SETTLE  = 4;
   localparam int          TB_TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [25:0] cmd_addr;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        ry;

   nor_cmd_seq_if #(.ADDRBITS(26), .DATABITS(16)) wb ();

   nor_cmd_seq #(
      .ADDRBITS(26), .DATABITS(16),
      .SETTLE_CYCLES(TB_SETTLE), .TIMEOUT_CYCLES(24'(TB_TIMEOUT))
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_addr_i  (cmd_addr),
      .cmd_data_i  (cmd_data),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (wb.cyc),
      .wbm_stb_o   (wb.stb),
      .wbm_we_o    (wb.we),
      .wbm_adr_o   (wb.adr),
      .wbm_dat_o   (wb.dat_w),
      .wbm_ack_i   (wb.ack),
      .wbm_stall_i (wb.stall),
      .wbm_dat_i   (wb.dat_r),
      .nor_ry_i    (ry)
   );

   always #5 clk = ~clk;

   typedef struct {logic we; logic [25:0] adr; logic [15:0] dat;} bus_t;
   // tmode: 0 no timing, 1 exact cycle tval, 2 timeout after last ack, 3 within 2 of accept
   typedef struct {logic [15:0] data; logic err; int tmode; int tval;} rsp_t;

   bus_t        exp_bus[$];
   rsp_t        exp_rsp[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc_cnt = 0;
   int          accept_cyc = 0;
   int          last_ack_cyc = 0;
   int          stall_cfg = 0;
   int          stall_left = 0;
   logic [15:0] rd_value = 16'h0;
   logic        cyc_seen = 1'b0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic push_bus(input logic we, input logic [25:0] a, input logic [15:0] d);
      bus_t e;
      e.we = we; e.adr = a; e.dat = d;
      exp_bus.push_back(e);
   endtask

   // NOR bus slave with programmable stalls and random ack latency; also
   // acts as the bus monitor, comparing each accepted op with the queue.
   initial begin : slave
      int   ack_wait;
      bus_t e;
      ack_wait  = -1;
      wb.ack    = 1'b0;
      wb.stall  = 1'b0;
      wb.dat_r  = 16'h0;
      forever begin
         @(negedge clk);
         #1;
         wb.ack   = 1'b0;
         wb.dat_r = 16'h0;
         wb.stall = 1'b0;
         if (wb.cyc) cyc_seen = 1'b1;
         if (rst) begin
            ack_wait   = -1;
            stall_left = stall_cfg;
         end else begin
            if (ack_wait == 0) begin
               wb.ack       = 1'b1;
               wb.dat_r     = rd_value;
               last_ack_cyc = cyc_cnt + 1;
               ack_wait     = -1;
            end else if (ack_wait > 0) begin
               ack_wait--;
            end
            if (wb.stb) begin
               if (stall_left > 0) begin
                  wb.stall = 1'b1;
                  stall_left--;
               end else begin
                  check("bus_cyc_high", wb.cyc, 1'b1);
                  if (exp_bus.size() == 0) begin
                     check("bus_unexpected_op", 1, 0);
                  end else begin
                     e = exp_bus.pop_front();
                     check("bus_we", wb.we, e.we);
                     check("bus_adr", wb.adr, e.adr);
                     if (e.we) check("bus_dat", wb.dat_w, e.dat);
                     $display("bus op we=%0d adr=%h dat=%h", wb.we, wb.adr, wb.dat_w);
                  end
                  ack_wait   = $urandom_range(0, 2);
                  stall_left = stall_cfg;
               end
            end
         end
      end
   end

   initial begin : rsp_monitor
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               r = exp_rsp.pop_front();
               $display("rsp data=%h err=%0d cycle=%0d", rsp_data, rsp_err, cyc_cnt);
               check("rsp_data", rsp_data, r.data);
               check("rsp_err", rsp_err, r.err);
               case (r.tmode)
                  1: check("rsp_cycle_after_ry", cyc_cnt, r.tval);
                  2: check("rsp_timeout_cycle", cyc_cnt, last_ack_cyc + TB_SETTLE + TB_TIMEOUT);
                  3: check("rsp_rsvd_latency", 32'(cyc_cnt - accept_cyc <= 2), 1);
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [25:0] a, input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      check("cmd_ready", cmd_ready, 1'b1);
      cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
      accept_cyc = cyc_cnt + 1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic push_seq(input logic [1:0] op, input logic [25:0] a, input logic [15:0] d);
      case (op)
         2'b00: push_bus(1'b0, a, 16'h0);
         2'b01: begin
            push_bus(1'b1, 26'h555, 16'hAA); push_bus(1'b1, 26'h2AA, 16'h55);
            push_bus(1'b1, 26'h555, 16'hA0); push_bus(1'b1, a, d);
         end
         2'b10: begin
            push_bus(1'b1, 26'h555, 16'hAA); push_bus(1'b1, 26'h2AA, 16'h55);
            push_bus(1'b1, 26'h555, 16'h80); push_bus(1'b1, 26'h555, 16'hAA);
            push_bus(1'b1, 26'h2AA, 16'h55); push_bus(1'b1, a, 16'h30);
         end
         default: ;
      endcase
   endtask

   // ry_delay < 0 means RY never rises for a PROGRAM/ERASE
   task automatic run_cmd(input logic [1:0] op, input logic [25:0] a, input logic [15:0] d,
                          input int stalls, input int ry_delay, input logic [15:0] rv);
      rsp_t r;
      int   n;
      logic is_wr;
      is_wr      = (op == 2'b01) || (op == 2'b10);
      stall_cfg  = stalls;
      stall_left = stalls;
      rd_value   = rv;
      push_seq(op, a, d);
      r.data = 16'h0; r.err = 1'b0; r.tmode = 0; r.tval = 0;
      if (op == 2'b00) begin
         r.data = rv;
      end else if (op == 2'b11) begin
         r.err = 1'b1; r.tmode = 3;
      end else if (ry_delay < 0) begin
         r.err = 1'b1; r.tmode = 2;
      end else begin
`ifdef NOR_CMD_VERIFY_EN
         push_bus(1'b0, a, 16'h0);
         r.data = rv;
         r.err  = (rv != ((op == 2'b01) ? d : 16'hFFFF));
`else
         r.tmode = 1;
`endif
      end
      exp_rsp.push_back(r);
      $display("cmd op=%0d addr=%h data=%h stalls=%0d ry_delay=%0d", op, a, d, stalls, ry_delay);
      ry       = is_wr ? 1'b0 : 1'b1;
      cyc_seen = 1'b0;
      issue(op, a, d);
      if (is_wr && ry_delay >= 0) begin
         n = 0;
         while (!wb.cyc && n < 100) begin @(negedge clk); n++; end
         n = 0;
         while (wb.cyc && n < 1000) begin @(negedge clk); n++; end
         repeat (ry_delay) @(negedge clk);
         ry = 1'b1;
         if (exp_rsp.size() > 0 && exp_rsp[0].tmode == 1) exp_rsp[0].tval = cyc_cnt + 1;
      end
      n = 0;
      while (exp_rsp.size() > 0 && n < 3000) begin @(negedge clk); n++; end
      check("rsp_arrived", exp_rsp.size(), 0);
      exp_rsp.delete();
      check("bus_ops_done", exp_bus.size(), 0);
      exp_bus.delete();
      if (op == 2'b11) check("rsvd_no_cyc", cyc_seen, 1'b0);
      ry = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_mid_program();
      int n = 0;
      stall_cfg = 0; stall_left = 0;
      push_seq(2'b01, 26'h001000, 16'h1234);
      $display("cmd op=1 addr=001000 data=1234 with reset at 3rd write");
      ry = 1'b0;
      issue(2'b01, 26'h001000, 16'h1234);
      while (!(wb.stb && wb.adr == 26'h555 && wb.dat_w == 16'hA0) && n < 200) begin
         @(negedge clk); n++;
      end
      check("rst_found_3rd_write", 32'(n < 200), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_cyc_low", wb.cyc, 1'b0);
      check("rst_stb_low", wb.stb, 1'b0);
      check("rst_ops_left", exp_bus.size(), 2);
      exp_bus.delete();
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("rst_ready_after", cmd_ready, 1'b1);
      ry = 1'b1;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [1:0]  op;
      logic [15:0] d, rv;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; ry = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", cmd_ready, 1'b1);
      check("reset_cyc", wb.cyc, 1'b0);
      check("reset_stb", wb.stb, 1'b0);
      check("reset_we", wb.we, 1'b0);
      check("reset_adr", wb.adr, 26'h0);
      check("reset_dat", wb.dat_w, 16'h0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_err", rsp_err, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_cmd(2'b00, 26'h000123, 16'h0000, 3, 0, 16'hBEEF);
      run_cmd(2'b01, 26'h001000, 16'h1234, 1, 50, 16'h1234);
      run_cmd(2'b10, 26'h020000, 16'h0000, 0, -1, 16'hFFFF);
      // RY rises on the final poll cycle: success must win over timeout
      run_cmd(2'b10, 26'h020000, 16'h0000, 2, TB_SETTLE + TB_TIMEOUT - 1, 16'hFFFF);
      reset_mid_program();
      run_cmd(2'b00, 26'h000456, 16'h0000, 0, 0, 16'h5A5A);
`ifdef NOR_CMD_VERIFY_EN
      run_cmd(2'b01, 26'h000200, 16'h00FF, 0, 10, 16'h00FE);
`endif
      run_cmd(2'b11, 26'h000010, 16'hAAAA, 0, 0, 16'h0000);

      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         d  = 16'($urandom);
         rv = 16'($urandom);
         if ($urandom_range(0, 1) == 1) rv = (op == 2'b01) ? d : 16'hFFFF;
         run_cmd(op, 26'($urandom), d, $urandom_range(0, 3), $urandom_range(TB_SETTLE, 30), rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nor_cmd_seq.md
NOR_CMD_SEQ -- requirements
Module: nor_cmd_seq

Interface
REQ-001 SHALL have parameter ADDRBITS, default 26, NOR word-address width.
REQ-002 SHALL have parameter DATABITS, default 16, NOR data width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, wait after the last command write before RY is sampled.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 24'd12_000_000, RY poll limit; 24-bit counter.
REQ-005 SHALL have port wb_clk_i, in, 1, the single clock.
REQ-006 SHALL have port wb_rst_i, in, 1, synchronous active-high reset.
REQ-007 SHALL have cmd_valid_i in 1, cmd_ready_o out 1, cmd_op_i in 2, cmd_addr_i in ADDRBITS, cmd_data_i in DATABITS: the command request.
REQ-008 SHALL have rsp_valid_o out 1, rsp_data_o out DATABITS, rsp_err_o out 1: the one-cycle response.
REQ-009 SHALL have Wishbone pipelined master ports wbm_cyc_o, wbm_stb_o, wbm_we_o (out 1), wbm_adr_o (out ADDRBITS), wbm_dat_o (out DATABITS), wbm_ack_i, wbm_stall_i (in 1) and wbm_dat_i (in DATABITS); these drive the NOR bus slave.
REQ-010 SHALL have nor_ry_i, in, 1: NOR ready/busy, 1 = ready.

Function
REQ-011 SHALL encode cmd_op_i as 00 READ, 01 PROGRAM, 10 SECTOR_ERASE and 11 reserved; a reserved op SHALL respond immediately with rsp_err_o=1 and issue no bus cycle.
REQ-012 SHALL accept a command when cmd_valid_i && cmd_ready_o; cmd_ready_o=1 only in IDLE; the op, address and data SHALL be latched on acceptance.
REQ-013 SHALL step through states IDLE -> ISSUE -> WAIT_ACK -> (ISSUE for the next step | SETTLE | RESP); SETTLE -> POLL -> RESP; then RESP -> IDLE.
REQ-014 SHALL issue these write sequences as (addr,data): READ: one read at cmd_addr. PROGRAM: (555h,AAh),(2AAh,55h),(555h,A0h),(cmd_addr,cmd_data). SECTOR_ERASE: (555h,AAh),(2AAh,55h),(555h,80h),(555h,AAh),(2AAh,55h),(cmd_addr,30h).
REQ-015 SHALL keep exactly one bus operation outstanding at a time.
- wbm_stb_o is held until a cycle with !wbm_stall_i.
- The machine then waits in WAIT_ACK for wbm_ack_i.
REQ-016 SHALL hold wbm_cyc_o high from the first ISSUE through the last ack of a command, and drop it in SETTLE, POLL and RESP.
REQ-017 SHALL count SETTLE_CYCLES cycles in SETTLE after the last PROGRAM/ERASE ack, then enter POLL.
REQ-018 SHALL leave POLL on the first cycle nor_ry_i=1 with err=0, or after TIMEOUT_CYCLES poll cycles with err=1.
REQ-019 SHALL assert rsp_valid_o for exactly one cycle in RESP.
- READ: rsp_data_o is wbm_dat_i captured at the ack.
- PROGRAM/ERASE: rsp_data_o=0.
REQ-020 SHALL let RY=1 and timeout coincide in the same cycle, in which case it SHALL report success.
REQ-021 SHALL zero-extend the unlock addresses and data to ADDRBITS/DATABITS.

Reset
REQ-022 SHALL on wb_rst_i, including mid-sequence, go to IDLE next edge.
- Cleared: wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o and the counters.
- Addr/data outputs: 0.
- cmd_ready_o=1 after reset deasserts.
- The aborted command produces no response.

Configuration
REQ-023 SHALL, with NOR_CMD_VERIFY_EN defined, do one read at cmd_addr after POLL succeeds.
- PROGRAM: rsp_err_o = (read != cmd_data).
- SECTOR_ERASE: rsp_err_o = (read != all-ones).
- rsp_data_o = the read value.
- Without the macro, there is no readback and REQ-019 applies.

Structure
REQ-024 SHALL place in package nor_cmd_pkg: the op encodings, the state enum, the unlock addresses/data constants and the sequence lengths (READ 1, PROGRAM 4, ERASE 6).
REQ-025 SHALL implement the step table as sub-module nor_cmd_rom.
- Inputs: op and step index.
- Outputs: addr_sel (fixed or cmd_addr), data_sel, we and last.
- Purely combinational.

Verification
REQ-026 SHALL cover READ at 0x000123 with the slave returning 0xBEEF, ack after 3 stalls: one read, rsp_data_o=0xBEEF, err=0.
REQ-027 SHALL cover PROGRAM at 0x001000 with data 0x1234: the 4 writes in REQ-014 order; RY is held low for 50 cycles; rsp_valid_o fires exactly 1 cycle after RY rises; err=0.
REQ-028 SHALL cover SECTOR_ERASE at 0x020000: 6 writes ending with (0x020000,0x30); RY is never asserted; with TIMEOUT_CYCLES=100, err=1 after 100 poll cycles.
REQ-029 SHALL cover wb_rst_i pulsed during the 3rd PROGRAM write: cyc/stb are low on the next edge, there is no rsp_valid_o, and the next READ works.
REQ-030 SHALL cover NOR_CMD_VERIFY_EN with PROGRAM 0x00FF whose readback returns 0x00FE: rsp_err_o=1 and rsp_data_o=0x00FE.
REQ-031 SHALL cover cmd_op_i=11: rsp_err_o=1 within 2 cycles and wbm_cyc_o never rises.
